// File: rtl/qnigma_math_pkg.sv
// rtl/qnigma_math_pkg.sv - shared math types for the modular ALU and its arbiters
package qnigma_math_pkg;

    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_CPY} alu_op_t;
    typedef logic [1:0]  pri_t;
    typedef logic [15:0] ptr_t;

    // 52-bit ALU task: operation, priority hint, two source words, one destination word
    typedef struct packed {
        alu_op_t op;
        pri_t    pri;
        ptr_t    rd_ptr_a;
        ptr_t    rd_ptr_b;
        ptr_t    wr_ptr;
    } task_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} arb_fsm_t;

    parameter int ARB_WDOG_DEF = 4096;

    localparam ptr_t ADDR_X2     = 16'h0040;
    localparam ptr_t ADDR_Z2     = 16'h0050;
    localparam ptr_t ADDR_MUL_LO = 16'h0080;

endpackage

// File: rtl/qnigma_rr_pick.sv
// rtl/qnigma_rr_pick.sv - combinational round-robin picker: first request at or after ptr
module qnigma_rr_pick #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] grant,
    output logic          any
);

    // Second pass overrides the wrap-around choice with the lowest index at or above ptr
    always_comb begin
        grant = '0;
        any   = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant = IW'(i);
                any   = 1'b1;
            end
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i] && (i >= int'(ptr))) begin
                grant = IW'(i);
            end
        end
    end

endmodule

// File: rtl/qnigma_alu_arb.sv
// rtl/qnigma_alu_arb.sv - arbitrates the shared modular ALU between requesters, with lock and watchdog
module qnigma_alu_arb
    import qnigma_math_pkg::*;
#(
    parameter  int NUM_REQ     = 2,
    parameter  int WDOG_CYCLES = ARB_WDOG_DEF,
    localparam int IW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_val,
    input  task_t [NUM_REQ-1:0]        req_tsk,
    input  logic [NUM_REQ-1:0]         req_lock,
    output logic [NUM_REQ-1:0]         req_rdy,
    output logic [NUM_REQ-1:0]         req_done,
    output logic [NUM_REQ-1:0]         req_err,
    output logic                       alu_val,
    output task_t                      alu_tsk,
    input  logic                       alu_rdy,
    input  logic                       alu_done,
    output logic [IW-1:0]              owner,
    output logic                       busy,
    output logic                       err_tmo
);

    localparam int WW = $clog2(WDOG_CYCLES) + 1;

    arb_fsm_t      state;
    logic [IW-1:0] rr_ptr;
    logic          lock_q;
    logic [WW-1:0] wdog;
    logic [IW-1:0] pick;
    logic          pick_any;
    logic [IW-1:0] acc_idx;
    logic [IW-1:0] nxt_owner;
    logic          accept;
    logic          wdog_hit;
    logic          finish;

    qnigma_rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
        .req   (req_val),
        .ptr   (rr_ptr),
        .grant (pick),
        .any   (pick_any)
    );

    assign nxt_owner = (int'(owner) == NUM_REQ - 1) ? '0 : owner + 1'b1;
    assign acc_idx   = (state == HOLD) ? owner : pick;
    assign accept    = |(req_val & req_rdy);
    assign busy      = (state != IDLE);
    // Trips on the edge where the counter would reach WDOG_CYCLES-1
    assign wdog_hit  = ((wdog + 1'b1) == WW'(WDOG_CYCLES - 1));
    assign finish    = alu_done && ((state == WAIT) || (state == ISSUE && alu_rdy));

    // Ready is held low while rst is asserted so nothing looks accepted during reset
    always_comb begin
        req_rdy = '0;
        if (!rst) begin
            if (state == IDLE && pick_any) begin
                req_rdy[pick] = 1'b1;
            end else if (state == HOLD) begin
                req_rdy[owner] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            owner    <= '0;
            lock_q   <= 1'b0;
            wdog     <= '0;
            alu_val  <= 1'b0;
            alu_tsk  <= '0;
            req_done <= '0;
            req_err  <= '0;
            err_tmo  <= 1'b0;
        end else begin
            req_done <= '0;
            req_err  <= '0;
            case (state)
                IDLE, HOLD: begin
                    if (accept) begin
                        alu_tsk <= req_tsk[acc_idx];
                        owner   <= acc_idx;
                        lock_q  <= req_lock[acc_idx];
                        alu_val <= 1'b1;
                        wdog    <= '0;
                        state   <= ISSUE;
                    end else if (state == HOLD && !req_lock[owner]) begin
                        rr_ptr <= nxt_owner;
                        state  <= IDLE;
                    end
                end
                ISSUE, WAIT: begin
                    wdog <= wdog + 1'b1;
                    if (state == ISSUE && alu_rdy) begin
                        alu_val <= 1'b0;
                    end
                    if (finish) begin
                        req_done[owner] <= 1'b1;
                        alu_val         <= 1'b0;
                        if (lock_q) begin
                            state <= HOLD;
                        end else begin
                            rr_ptr <= nxt_owner;
                            state  <= IDLE;
                        end
                    end else if (wdog_hit) begin
                        err_tmo         <= 1'b1;
                        req_done[owner] <= 1'b1;
                        req_err[owner]  <= 1'b1;
                        lock_q          <= 1'b0;
                        rr_ptr          <= nxt_owner;
                        alu_val         <= 1'b0;
                        state           <= IDLE;
                    end else if (state == ISSUE && alu_rdy) begin
                        state <= WAIT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qnigma_alu_arb.sv
// tb/tb_qnigma_alu_arb.sv - directed self-checking bench for qnigma_alu_arb
module tb_qnigma_alu_arb;
    import qnigma_math_pkg::*;

    logic        clk;
    logic        rst;
    logic [1:0]  req_val;
    task_t [1:0] req_tsk;
    logic [1:0]  req_lock;
    logic        alu_rdy;
    logic        alu_done;

    logic [1:0]  req_rdy, req_done, req_err;
    logic        alu_val, busy, err_tmo;
    task_t       alu_tsk;
    logic [0:0]  owner;

    logic [1:0]  w_req_rdy, w_req_done, w_req_err;
    logic        w_alu_val, w_busy, w_err_tmo;
    task_t       w_alu_tsk;
    logic [0:0]  w_owner;

    int tests_run;
    int tests_failed;

    task_t t_a, t_b, t_c, t_d, t_e;

    qnigma_alu_arb #(.NUM_REQ(2)) dut (
        .clk(clk), .rst(rst), .req_val(req_val), .req_tsk(req_tsk), .req_lock(req_lock),
        .req_rdy(req_rdy), .req_done(req_done), .req_err(req_err),
        .alu_val(alu_val), .alu_tsk(alu_tsk), .alu_rdy(alu_rdy), .alu_done(alu_done),
        .owner(owner), .busy(busy), .err_tmo(err_tmo)
    );

    qnigma_alu_arb #(.NUM_REQ(2), .WDOG_CYCLES(16)) dut_w (
        .clk(clk), .rst(rst), .req_val(req_val), .req_tsk(req_tsk), .req_lock(req_lock),
        .req_rdy(w_req_rdy), .req_done(w_req_done), .req_err(w_req_err),
        .alu_val(w_alu_val), .alu_tsk(w_alu_tsk), .alu_rdy(alu_rdy), .alu_done(alu_done),
        .owner(w_owner), .busy(w_busy), .err_tmo(w_err_tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        step();
    endtask

    // Plays the ALU: waits for issue, accepts after rdy_dly cycles, completes after done_dly more
    task automatic run_alu(input string tag, input int exp_own, input task_t exp_tsk,
                           input int rdy_dly, input int done_dly);
        int n;
        n = 0;
        while (!alu_val && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_val"}, 64'(alu_val), 64'd1);
        chk({tag, "_own"}, 64'(owner), 64'(exp_own));
        chk({tag, "_tsk"}, 64'(alu_tsk), 64'(exp_tsk));
        repeat (rdy_dly) step();
        alu_rdy = 1'b1;
        step();
        alu_rdy = 1'b0;
        repeat (done_dly) step();
        chk({tag, "_pre"}, 64'(req_done), 64'd0);
        alu_done = 1'b1;
        step();
        alu_done = 1'b0;
        chk({tag, "_done"}, 64'(req_done), 64'(1 << exp_own));
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        t_a = '{op: OP_MUL, pri: 2'd0, rd_ptr_a: ADDR_X2, rd_ptr_b: ADDR_Z2, wr_ptr: ADDR_MUL_LO};
        t_b = '{op: OP_ADD, pri: 2'd1, rd_ptr_a: 16'h0011, rd_ptr_b: 16'h0022, wr_ptr: 16'h0033};
        t_c = '{op: OP_SUB, pri: 2'd2, rd_ptr_a: 16'h0100, rd_ptr_b: 16'h0101, wr_ptr: 16'h0102};
        t_d = '{op: OP_CPY, pri: 2'd3, rd_ptr_a: 16'hBEEF, rd_ptr_b: 16'h1234, wr_ptr: 16'hCAFE};
        t_e = '{op: OP_ADD, pri: 2'd0, rd_ptr_a: 16'h0007, rd_ptr_b: 16'h0008, wr_ptr: 16'h0009};
        rst = 1'b1; req_val = '0; req_lock = '0; req_tsk = '{default: '0};
        alu_rdy = 1'b0; alu_done = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();

        chk("rst_alu_val", 64'(alu_val), 64'd0);
        chk("rst_alu_tsk", 64'(alu_tsk), 64'd0);
        chk("rst_req_rdy", 64'(req_rdy), 64'd0);
        chk("rst_busy",    64'(busy),    64'd0);
        chk("rst_err_tmo", 64'(err_tmo), 64'd0);
        chk("rst_owner",   64'(owner),   64'd0);

        // Single mul task from the ECP side
        req_tsk[0] = t_a;
        req_val    = 2'b01;
        #1;
        chk("single_rdy", 64'(req_rdy), 64'b01);
        step();
        req_val = 2'b00;
        chk("single_busy", 64'(busy), 64'd1);
        run_alu("single", 0, t_a, 1, 19);
        chk("single_idle", 64'(busy), 64'd0);
        step();
        chk("single_pulse", 64'(req_done), 64'd0);

        // Fairness: both requesters stream unlocked tasks
        do_reset();
        req_tsk[0] = t_c;
        req_tsk[1] = t_b;
        req_val    = 2'b11;
        for (int i = 0; i < 8; i++) begin
            run_alu($sformatf("fair%0d", i), i % 2, (i % 2 == 0) ? t_c : t_b, 0, 1);
        end
        req_val = 2'b00;
        step();

        // Lock: requester 0 keeps the ALU for three tasks while requester 1 waits
        do_reset();
        req_tsk[0] = t_c;
        req_tsk[1] = t_b;
        req_lock   = 2'b01;
        req_val    = 2'b11;
        run_alu("lock0", 0, t_c, 0, 2);
        chk("lock_hold_rdy", 64'(req_rdy), 64'b01);
        run_alu("lock1", 0, t_c, 0, 2);
        run_alu("lock2", 0, t_c, 0, 2);
        req_val = 2'b10;
        #1;
        chk("lock_wait_rdy", 64'(req_rdy), 64'b01);
        step();
        chk("lock_wait_val", 64'(alu_val), 64'd0);
        chk("lock_wait_busy", 64'(busy), 64'd1);
        req_lock = 2'b00;
        step();
        chk("lock_rel_rdy", 64'(req_rdy), 64'b10);
        run_alu("lock_r1", 1, t_b, 0, 2);
        req_val = 2'b00;

        // Backpressure: ALU refuses the task for 10 cycles
        req_tsk[0] = t_d;
        req_val    = 2'b01;
        step();
        req_val = 2'b11;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk($sformatf("bp_val%0d", i), 64'(alu_val), 64'd1);
            chk($sformatf("bp_tsk%0d", i), 64'(alu_tsk), 64'(t_d));
            chk($sformatf("bp_rdy%0d", i), 64'(req_rdy), 64'd0);
            step();
        end
        req_val = 2'b00;
        alu_rdy = 1'b1;
        step();
        alu_rdy  = 1'b0;
        alu_done = 1'b1;
        step();
        alu_done = 1'b0;
        chk("bp_done", 64'(req_done), 64'b01);

        // Watchdog on the 16-cycle instance; the ALU never completes
        do_reset();
        req_tsk[0] = t_e;
        req_val    = 2'b01;
        step();
        req_val = 2'b00;
        for (int k = 1; k <= 14; k++) begin
            alu_rdy = (k == 2);
            step();
        end
        alu_rdy = 1'b0;
        chk("wd_early_done", 64'(w_req_done), 64'd0);
        chk("wd_early_tmo",  64'(w_err_tmo),  64'd0);
        step();
        chk("wd_done", 64'(w_req_done), 64'b01);
        chk("wd_err",  64'(w_req_err),  64'b01);
        chk("wd_tmo",  64'(w_err_tmo),  64'd1);
        chk("wd_idle", 64'(w_busy),     64'd0);
        step();
        chk("wd_err_pulse", 64'(w_req_err), 64'd0);
        chk("wd_sticky",    64'(w_err_tmo), 64'd1);
        req_val = 2'b01;
        #1;
        chk("wd_next_rdy", 64'(w_req_rdy), 64'b01);
        step();
        req_val = 2'b00;
        chk("wd_next_val", 64'(w_alu_val), 64'd1);
        chk("wd_next_own", 64'(w_owner),   64'd0);
        alu_rdy = 1'b1;
        step();
        alu_rdy  = 1'b0;
        alu_done = 1'b1;
        step();
        alu_done = 1'b0;
        chk("wd_next_done",  64'(w_req_done), 64'b01);
        chk("wd_next_noerr", 64'(w_req_err),  64'd0);
        chk("wd_next_tmo",   64'(w_err_tmo),  64'd1);

        // Asynchronous reset while requester 1's task is in WAIT
        do_reset();
        chk("rst_clears_tmo", 64'(w_err_tmo), 64'd0);
        req_tsk[1] = t_d;
        req_val    = 2'b10;
        step();
        req_val = 2'b00;
        alu_rdy = 1'b1;
        step();
        alu_rdy = 1'b0;
        step();
        chk("mid_busy", 64'(busy),  64'd1);
        chk("mid_own",  64'(owner), 64'd1);
        rst     = 1'b1;
        req_val = 2'b01;
        #1;
        chk("arst_busy",  64'(busy),    64'd0);
        chk("arst_own",   64'(owner),   64'd0);
        chk("arst_tsk",   64'(alu_tsk), 64'd0);
        chk("arst_rdy",   64'(req_rdy), 64'd0);
        req_val = 2'b00;
        #1;
        rst = 1'b0;
        step();
        alu_done = 1'b1;
        step();
        alu_done = 1'b0;
        chk("late_done", 64'(req_done), 64'd0);
        chk("late_busy", 64'(busy),     64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
